overlap_sequencer: RTL and testbench
====================================

# overlap_sequencer

Controller for the overlap-add stage of the windowed synthesis path. It sequences a single-port overlap buffer of `halfWindowSize` words, one frame at a time:
- **ADD phase:** each first-half sample of the current frame is added, with saturation, to the saved second half of the previous frame, and the sum is emitted.
- **SAVE phase:** the second half of the current frame is written into the buffer for the next frame.
- **CLEAR phase:** after reset the buffer is zeroed so that the first frame overlaps with silence.

## Interface
- `halfWindowSize`, 512: N, samples per half window; buffer depth.
- `wordLength`, 16: sample width, signed two's complement.
- `addrWidth`, 9: buffer address width; must satisfy 2^addrWidth >= N.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame start request; sampled only in IDLE.
- `inValid`  in  1  `inData` valid.
- `inReady`  out  1  sample accepted when `inValid && inReady`.
- `inData`  in  wordLength  frame samples in order: N first-half samples, then N second-half samples.
- `outValid`  out  1  one-cycle strobe; `outData` valid. There is no backpressure.
- `outData`  out  wordLength  saturated overlap-add sum.
- `frameDone`  out  1  one-cycle pulse after the last SAVE write.
- `busy`  out  1  high in every state except IDLE.
- `memAddr`  out  addrWidth  buffer address.
- `memWe`  out  1  buffer write enable.
- `memWdata`  out  wordLength  buffer write data.
- `memRe`  out  1  buffer read enable.
- `memRdata`  in  wordLength  read data, valid the cycle after `memRe`.

## Operation
- **States:** CLEAR, IDLE, ADD, SAVE. An index counter `idx` runs 0..N-1; `memAddr = idx`.
- **CLEAR**
  - Entered from any state when `rst` is high; `idx` is set to 0.
  - Each cycle: `memWe=1`, `memWdata=0`, then `idx++`.
  - After the write at idx = N-1: go to IDLE, `idx=0`.
  - `inReady=0` throughout.
- **IDLE**
  - `inReady=0`, `busy=0`.
  - `start=1` moves to ADD. `start` in any other state is ignored.
- **ADD**
  - `inReady=1`.
  - On accept: `memRe=1`, the sample is registered, then `idx++`.
  - Next cycle: sum = `memRdata` + registered sample, computed at wordLength+1 bits and clamped to [-2^(wordLength-1), 2^(wordLength-1)-1]. The clamped sum is registered into `outData` and `outValid` pulses the following cycle.
  - After the N-th accept: go to SAVE, `idx=0`.
- **SAVE**
  - `inReady=1`.
  - On accept: `memWe=1`, `memWdata=inData`, then `idx++`.
  - After the N-th accept: go to IDLE and pulse `frameDone` on the next cycle.
- **Memory controls:** `memWe`, `memRe` and `memWdata` are combinational from state, `idx`, `inValid` and `inData`, and are forced to 0 while `rst=1`. `memWe` and `memRe` are never high in the same cycle.
- **Cycles without accept:** `inValid=0` in ADD or SAVE stalls `idx`; no memory access occurs.
- **Phase boundaries:** ADD pipeline results in flight at the ADD→SAVE transition still complete; SAVE writes do not disturb them.
- **Reset mid-frame:** on `rst`, all in-flight ADD results are discarded (no `outValid`), `idx=0`, and the state is CLEAR. The buffer is fully re-zeroed.

## Timing
- **Reset values:** `inReady=0`, `outValid=0`, `outData=0`, `frameDone=0`, `busy=1` (CLEAR), `memWe=memRe=0` during the `rst` cycle.
- **CLEAR duration:** exactly N cycles after `rst` deasserts; IDLE on cycle N+1.
- **ADD latency:** accept at cycle t, `memRdata` used at t+1, `outValid` at t+2.
- **ADD throughput:** back-to-back accepts give one `outValid` per cycle.
- **Minimum frame length:** 1 (start) + 2N cycles with continuous `inValid`; `frameDone` is 1 cycle after the last SAVE accept.

## Test plan
All scenarios use N=4, wordLength=16.
- **Reset then clear:** `rst` for 1 cycle → `memWe=1`, `memWdata=0` at addresses 0,1,2,3 on consecutive cycles, then `busy=0`.
- **First frame:** inputs 1,2,3,4 (ADD) and 10,20,30,40 (SAVE) → `outData` 1,2,3,4 at accept+2; buffer holds 10,20,30,40; `frameDone` pulses once.
- **Second frame:** inputs 5,6,7,8 and then 0,0,0,0 → outputs 15,26,37,48.
- **Saturation:** saved 0x7000, input 0x7000 → output 0x7FFF. Saved 0x8000, input 0xFFFF → output 0x8000.
- **Stalls and stray start:** `inValid` toggled 1,0,1,0 in ADD, with `start` pulsed mid-ADD → `idx` advances only on accepts; outputs correct and in order; the `start` has no effect.
- **Reset mid-ADD:** `rst` after 2 accepts → no further `outValid`; a full CLEAR follows; the next frame's outputs equal its inputs.

Source files
------------

// File: rtl/overlap_sequencer.sv
// Overlap-add controller: clears the overlap buffer after reset, then per frame
// adds first-half samples to the saved half (saturating) and saves the second half.
module overlap_sequencer #(
  parameter int halfWindowSize = 512,
  parameter int wordLength     = 16,
  parameter int addrWidth      = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [wordLength-1:0] inData,
  output logic                  outValid,
  output logic [wordLength-1:0] outData,
  output logic                  frameDone,
  output logic                  busy,
  output logic [addrWidth-1:0]  memAddr,
  output logic                  memWe,
  output logic [wordLength-1:0] memWdata,
  output logic                  memRe,
  input  logic [wordLength-1:0] memRdata
);

  typedef enum logic [1:0] {CLEAR, IDLE, ADD, SAVE} state_t;

  localparam logic [addrWidth-1:0] LAST_IDX = addrWidth'(halfWindowSize - 1);

  state_t                state_reg, state_next;
  logic [addrWidth-1:0]  idx_reg, idx_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  add_pend_reg;
  logic [wordLength-1:0] sample_reg;
  logic                  out_valid_reg;
  logic [wordLength-1:0] out_data_reg;
  logic [wordLength:0]   sum_wide;
  logic [wordLength-1:0] sum_sat;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    inReady         = 1'b0;
    memWe           = 1'b0;
    memRe           = 1'b0;
    memWdata        = '0;
    frame_done_next = 1'b0;
    case (state_reg)
      CLEAR: begin
        memWe = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      IDLE: begin
        if (start) state_next = ADD;
      end
      ADD: begin
        inReady = 1'b1;
        if (inValid) begin
          memRe = 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = SAVE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      SAVE: begin
        inReady = 1'b1;
        if (inValid) begin
          memWe    = 1'b1;
          memWdata = inData;
          if (idx_reg == LAST_IDX) begin
            state_next      = IDLE;
            idx_next        = '0;
            frame_done_next = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = CLEAR;
    endcase
    // Reset must never leak a buffer access or an accept, even for one cycle.
    if (rst) begin
      inReady  = 1'b0;
      memWe    = 1'b0;
      memRe    = 1'b0;
      memWdata = '0;
    end
  end

  // One extra bit holds the true sum; disagreeing top bits mean overflow.
  always_comb begin
    sum_wide = {memRdata[wordLength-1], memRdata} + {sample_reg[wordLength-1], sample_reg};
    sum_sat  = sum_wide[wordLength-1:0];
    if (sum_wide[wordLength] != sum_wide[wordLength-1]) begin
      sum_sat = sum_wide[wordLength] ? {1'b1, {(wordLength-1){1'b0}}}
                                     : {1'b0, {(wordLength-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= CLEAR;
      idx_reg        <= '0;
      frame_done_reg <= 1'b0;
      add_pend_reg   <= 1'b0;
      sample_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      frame_done_reg <= frame_done_next;
      add_pend_reg   <= memRe;
      if (memRe) sample_reg <= inData;
      out_valid_reg  <= add_pend_reg;
      if (add_pend_reg) out_data_reg <= sum_sat;
    end
  end

  assign memAddr   = idx_reg;
  assign outValid  = out_valid_reg;
  assign outData   = out_data_reg;
  assign frameDone = frame_done_reg;
  assign busy      = rst || (state_reg != IDLE);

endmodule

// File: tb/tb_overlap_sequencer.sv
// Scoreboard bench for overlap_sequencer (N=4): stimulus pushes expected sums,
// a negedge monitor pops and compares whenever outValid is presented.
module tb_overlap_sequencer;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [W-1:0]  inData = '0;
  logic          outValid;
  logic [W-1:0]  outData;
  logic          frameDone;
  logic          busy;
  logic [AW-1:0] memAddr;
  logic          memWe;
  logic [W-1:0]  memWdata;
  logic          memRe;
  logic [W-1:0]  memRdata;

  logic [W-1:0]  mem [0:N-1];
  logic [W-1:0]  exp_q [$];
  int            applied = 0;
  int            miscompares = 0;
  int            idx_exp = 0;
  int            out_count = 0;

  overlap_sequencer #(.halfWindowSize(N), .wordLength(W), .addrWidth(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .inValid(inValid), .inReady(inReady),
    .inData(inData), .outValid(outValid), .outData(outData), .frameDone(frameDone),
    .busy(busy), .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata),
    .memRe(memRe), .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  // Single-port buffer with registered read; starts filled with junk.
  initial for (int i = 0; i < N; i++) mem[i] = 16'hDEAD;
  always @(posedge clk) begin
    if (memWe) mem[memAddr] <= memWdata;
    if (memRe) memRdata <= mem[memAddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (outValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL outValid: got unexpected result %0h, expected none", outData);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        $display("out %0d: data=%04h expected=%04h", out_count, outData, e);
        check("outData", outData, e);
      end
      out_count++;
    end
  end

  task automatic send(input logic [W-1:0] d, input bit is_add, input bit push, input logic [W-1:0] e);
    int n = 0;
    @(negedge clk);
    inValid = 1'b1;
    inData  = d;
    #1;
    while (inReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("inReady", inReady, 1);
    check("memAddr", memAddr, idx_exp);
    if (is_add) begin
      check("memRe", memRe, 1);
    end else begin
      check("memWe", memWe, 1);
      check("memWdata", memWdata, d);
    end
    if (push) exp_q.push_back(e);
    idx_exp = (idx_exp + 1) % N;
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      inValid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inValid = 1'b0; start = 1'b0;
    #1;
    check("memWe in rst", memWe, 0);
    check("memRe in rst", memRe, 0);
    check("busy in rst", busy, 1);
    check("inReady in rst", inReady, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("outValid reset", outValid, 0);
    check("outData reset", outData, 0);
    check("frameDone reset", frameDone, 0);
    for (int i = 0; i < N; i++) begin
      check("clear memWe", memWe, 1);
      check("clear memWdata", memWdata, 0);
      check("clear memAddr", memAddr, i);
      check("clear busy", busy, 1);
      check("clear inReady", inReady, 0);
      @(negedge clk);
      #1;
    end
    check("busy after clear", busy, 0);
    idx_exp = 0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    #1;
    check("busy idle", busy, 0);
    check("inReady idle", inReady, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx_exp = 0;
  endtask

  task automatic save_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
    send(a, 0, 0, 0);
    send(b, 0, 0, 0);
    send(c, 0, 0, 0);
    send(d, 0, 0, 0);
    @(negedge clk);
    inValid = 1'b0;
    #1;
    check("frameDone pulse", frameDone, 1);
    @(negedge clk);
    #1;
    check("frameDone single", frameDone, 0);
    check("busy after frame", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Frame 1: overlap with silence.
    start_frame();
    send(1, 1, 1, 1); send(2, 1, 1, 2); send(3, 1, 1, 3); send(4, 1, 1, 4);
    save_frame(10, 20, 30, 40);
    check("buf0", mem[0], 10); check("buf1", mem[1], 20);
    check("buf2", mem[2], 30); check("buf3", mem[3], 40);

    // Frame 2: 5..8 on top of 10..40.
    start_frame();
    send(5, 1, 1, 15); send(6, 1, 1, 26); send(7, 1, 1, 37); send(8, 1, 1, 48);
    save_frame(0, 0, 0, 0);

    // Frame 3 loads the saturation operands.
    start_frame();
    send(0, 1, 1, 0); send(0, 1, 1, 0); send(0, 1, 1, 0); send(0, 1, 1, 0);
    save_frame(16'h7000, 16'h8000, 0, 0);

    // Frame 4: positive and negative clamp.
    start_frame();
    send(16'h7000, 1, 1, 16'h7FFF); send(16'hFFFF, 1, 1, 16'h8000);
    send(1, 1, 1, 1); send(2, 1, 1, 2);
    save_frame(1, 1, 1, 1);

    // Frame 5: stalls and a stray start in ADD.
    start_frame();
    send(3, 1, 1, 4);
    stall(1);
    send(4, 1, 1, 5);
    @(negedge clk);
    inValid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(5, 1, 1, 6);
    stall(1);
    send(6, 1, 1, 7);
    save_frame(9, 9, 9, 9);

    // Frame 6: reset with the second result still in flight.
    start_frame();
    send(7, 1, 1, 16);
    stall(2);
    send(8, 1, 0, 0);
    do_reset();

    // Frame 7: buffer must be silent again.
    start_frame();
    send(100, 1, 1, 100); send(200, 1, 1, 200); send(300, 1, 1, 300); send(400, 1, 1, 400);
    save_frame(0, 0, 0, 0);

    stall(4);
    check("scoreboard drained", exp_q.size(), 0);
    check("result count", out_count, 25);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
